// File: rtl/mb_dff_checker.sv
// Response-side monitor for a master-slave D flip-flop under test: synchronizes the
// flop's stimulus and outputs, runs a golden model, and compares after a settle window.
module mb_dff_checker #(
  parameter int SYNC_STAGES = 2,
  parameter int SETTLE      = 4,
  parameter int CNT_W       = 8,
  parameter bit POS_EDGE    = 1'b1
) (
  input  logic             Cp,
  input  logic             R,
  input  logic             dut_cp,
  input  logic             dut_sn,
  input  logic             dut_rn,
  input  logic             dut_d,
  input  logic             dut_q,
  input  logic             dut_qn,
  output logic             exp_q,
  output logic             exp_qn,
  output logic             err_pulse,
  output logic             err_flag,
  output logic             illegal,
  output logic [CNT_W-1:0] edge_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int NIN  = 6;
  localparam int WU_W = $clog2(SYNC_STAGES + 2);
  localparam logic [WU_W-1:0]  WU_INIT = WU_W'(SYNC_STAGES + 1);
  localparam logic [3:0]       SET_LD  = 4'(SETTLE);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {IDLE, SETTLE_W, CHECK} state_t;

  logic [SYNC_STAGES-1:0][NIN-1:0] sync_q, sync_d;
  logic [3:0]      prev_q, prev_d;
  logic [WU_W-1:0] wu_q, wu_d;
  logic            mq_q, mq_d, mqn_q, mqn_d, illegal_q, illegal_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;

  state_t          state_q;
  logic [3:0]      cnt_q;
  logic            err_pulse_q, err_flag_q;
  logic [CNT_W-1:0] err_cnt_q;

  logic cp_s, sn_s, rn_s, d_s, q_s, qn_s;
  logic live, act_edge, evt, mismatch;

  always_comb begin
    sync_d[0] = {dut_qn, dut_q, dut_d, dut_rn, dut_sn, dut_cp};
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
  end

  assign {qn_s, q_s, d_s, rn_s, sn_s, cp_s} = sync_q[SYNC_STAGES-1];

  // Events are suppressed until both the synchronizers and the delayed copies hold
  // post-reset samples, so the zeros loaded at reset never look like pin activity.
  assign live     = (wu_q == '0);
  assign act_edge = live && (POS_EDGE ? (cp_s & ~prev_q[0]) : (~cp_s & prev_q[0]));
  assign evt      = live && (act_edge || (sn_s ^ prev_q[1]) || (rn_s ^ prev_q[2]));
  assign mismatch = (q_s != mq_q) || (qn_s != mqn_q);

  always_comb begin
    prev_d     = {d_s, rn_s, sn_s, cp_s};
    wu_d       = live ? wu_q : wu_q - 1'b1;
    mq_d       = mq_q;
    mqn_d      = mqn_q;
    illegal_d  = 1'b0;
    edge_cnt_d = edge_cnt_q;
    if (live) begin
      if (!sn_s && !rn_s) begin
        mq_d      = 1'b1;
        mqn_d     = 1'b1;
        illegal_d = 1'b1;
      end else if (!sn_s) begin
        mq_d  = 1'b1;
        mqn_d = 1'b0;
      end else if (!rn_s) begin
        mq_d  = 1'b0;
        mqn_d = 1'b1;
      end else if (act_edge) begin
        // Capture the data seen one cycle before the edge, as the master latch did.
        mq_d  = prev_q[3];
        mqn_d = ~prev_q[3];
        if (edge_cnt_q != CNT_MAX) edge_cnt_d = edge_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Cp or posedge R) begin
    if (R) begin
      sync_q     <= '0;
      prev_q     <= '0;
      wu_q       <= WU_INIT;
      mq_q       <= 1'b0;
      mqn_q      <= 1'b1;
      illegal_q  <= 1'b0;
      edge_cnt_q <= '0;
    end else begin
      sync_q     <= sync_d;
      prev_q     <= prev_d;
      wu_q       <= wu_d;
      mq_q       <= mq_d;
      mqn_q      <= mqn_d;
      illegal_q  <= illegal_d;
      edge_cnt_q <= edge_cnt_d;
    end
  end

  // Settle/compare sequencer; err_pulse is high for the single CHECK cycle.
  always_ff @(posedge Cp or posedge R) begin
    if (R) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      err_pulse_q <= 1'b0;
      err_flag_q  <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      err_pulse_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (evt) begin
            state_q <= SETTLE_W;
            cnt_q   <= SET_LD;
          end
        end
        SETTLE_W: begin
          if (evt) begin
            cnt_q <= SET_LD;
          end else if (cnt_q == '0) begin
            state_q     <= CHECK;
            err_pulse_q <= mismatch;
            if (mismatch) begin
              err_flag_q <= 1'b1;
              if (err_cnt_q != CNT_MAX) err_cnt_q <= err_cnt_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        CHECK: begin
          state_q <= evt ? SETTLE_W : IDLE;
          if (evt) cnt_q <= SET_LD;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign exp_q     = mq_q;
  assign exp_qn    = mqn_q;
  assign illegal   = illegal_q;
  assign edge_cnt  = edge_cnt_q;
  assign err_pulse = err_pulse_q;
  assign err_flag  = err_flag_q;
  assign err_cnt   = err_cnt_q;

endmodule
